// File: rtl/debug_unit_pkg.sv
// rtl/debug_unit_pkg.sv - command codes, ACK byte and FSM states for the MIPS debug unit
package debug_unit_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] ACK_BYTE = 8'h06;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_CNT,
        LOAD_BYTE,
        LOAD_WRITE,
        LOAD_ACK,
        ACK_SEND,
        RUN,
        STEP,
        DUMP_SET,
        DUMP_WAIT,
        DUMP_CAP,
        DUMP_SEND
    } stateT;

endpackage

// File: rtl/debug_word_serializer.sv
// rtl/debug_word_serializer.sv - captures one word and sends it LSB byte first over a valid/ready stream
module debug_word_serializer #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               load,
    input  logic               single,
    input  logic [NB_DATA-1:0] word,
    output logic [NB_BYTE-1:0] txTdata,
    output logic               txTvalid,
    input  logic               txTready,
    output logic               busy
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int CNT_W   = $clog2(N_BYTES + 1);

    logic [NB_DATA-1:0] shiftReg;
    logic [CNT_W-1:0]   remaining;

    assign busy = (remaining != '0);

    // A load is only honoured while idle; the next byte is presented the cycle after each handshake.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shiftReg  <= '0;
            remaining <= '0;
            txTdata   <= '0;
            txTvalid  <= 1'b0;
        end else if (remaining == '0) begin
            if (load) begin
                shiftReg  <= word >> NB_BYTE;
                txTdata   <= word[NB_BYTE-1:0];
                txTvalid  <= 1'b1;
                remaining <= single ? CNT_W'(1) : CNT_W'(N_BYTES);
            end
        end else if (txTvalid && txTready) begin
            if (remaining == CNT_W'(1)) begin
                txTvalid  <= 1'b0;
                remaining <= '0;
            end else begin
                txTdata   <= shiftReg[NB_BYTE-1:0];
                shiftReg  <= shiftReg >> NB_BYTE;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART-driven program load, run/step and state dump controller for the MIPS pipeline
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int NB_PC          = 32,
    parameter int N_REG          = 32,
    parameter int NB_BYTE        = 8,
    parameter int MEM_DUMP_WORDS = 16,
    parameter int MAX_RUN_CYCLES = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NB_BYTE-1:0]       i_rx_data,
    input  logic                     i_rx_valid,
    output logic [NB_BYTE-1:0]       o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic                     o_cpu_rst,
    output logic                     o_pipe_enabled,
    output logic                     o_instruction_write,
    output logic [NB_PC-1:0]         o_instruction_addr,
    output logic [NB_DATA-1:0]       o_instruction_data,
    output logic [$clog2(N_REG)-1:0] o_reg_index_addr,
    input  logic [NB_DATA-1:0]       i_reg_data,
    output logic [NB_DATA-1:0]       o_memory_addr,
    input  logic [NB_DATA-1:0]       i_memory_data,
    input  logic [NB_PC-1:0]         i_pc_count
);

    localparam int IDX_W      = $clog2(N_REG);
    localparam int DUMP_WORDS = 1 + N_REG + MEM_DUMP_WORDS;
    localparam int DIDX_W     = $clog2(DUMP_WORDS);
    localparam int CYC_W      = $clog2(MAX_RUN_CYCLES + 1);
    localparam int BI_W       = $clog2(NB_DATA / NB_BYTE);

    stateT              state;
    logic [NB_BYTE-1:0] wordCnt;
    logic [NB_BYTE-1:0] wordIdx;
    logic [BI_W-1:0]    byteIdx;
    logic [NB_DATA-1:0] instrBuf;
    logic [NB_PC-1:0]   endAddr;
    logic [CYC_W-1:0]   cycleCnt;
    logic               ackCnt;
    logic [DIDX_W-1:0]  dumpIdx;
    logic               runGo;
    logic               serLoad;
    logic               serSingle;
    logic [NB_DATA-1:0] serWord;
    logic               serBusy;

    // Enable is decided from the current PC, so a PC already at end_addr never gets an enabled cycle.
    assign runGo = (state == RUN) && (i_pc_count != endAddr)
                   && (cycleCnt != CYC_W'(MAX_RUN_CYCLES));
    assign o_pipe_enabled = runGo || (state == STEP);

    assign serLoad   = (state == DUMP_CAP) || ((state == LOAD_ACK) && ackCnt);
    assign serSingle = (state == LOAD_ACK);

    always_comb begin
        serWord = i_memory_data;
        if (state == LOAD_ACK)
            serWord = NB_DATA'(ACK_BYTE);
        else if (dumpIdx == '0)
            serWord = NB_DATA'(i_pc_count);
        else if (dumpIdx <= DIDX_W'(N_REG))
            serWord = i_reg_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= IDLE;
            o_cpu_rst           <= 1'b1;
            o_instruction_write <= 1'b0;
            o_instruction_addr  <= '0;
            o_instruction_data  <= '0;
            o_reg_index_addr    <= '0;
            o_memory_addr       <= '0;
            wordCnt             <= '0;
            wordIdx             <= '0;
            byteIdx             <= '0;
            instrBuf            <= '0;
            endAddr             <= '0;
            cycleCnt            <= '0;
            ackCnt              <= 1'b0;
            dumpIdx             <= '0;
        end else begin
            o_cpu_rst           <= 1'b0;
            o_instruction_write <= 1'b0;
            case (state)
                IDLE: begin
                    dumpIdx  <= '0;
                    cycleCnt <= '0;
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: state <= LOAD_CNT;
                            CMD_RUN:  state <= RUN;
                            CMD_STEP: state <= STEP;
                            CMD_DUMP: state <= DUMP_SET;
                            default:  state <= IDLE;
                        endcase
                    end
                end
                LOAD_CNT: begin
                    if (i_rx_valid) begin
                        wordCnt <= i_rx_data;
                        wordIdx <= '0;
                        byteIdx <= '0;
                        if (i_rx_data == '0) begin
                            endAddr   <= '0;
                            ackCnt    <= 1'b0;
                            o_cpu_rst <= 1'b1;
                            state     <= LOAD_ACK;
                        end else begin
                            state <= LOAD_BYTE;
                        end
                    end
                end
                LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        instrBuf <= {i_rx_data, instrBuf[NB_DATA-1:NB_BYTE]};
                        byteIdx  <= byteIdx + BI_W'(1);
                        if (byteIdx == '1) begin
                            o_instruction_data  <= {i_rx_data, instrBuf[NB_DATA-1:NB_BYTE]};
                            o_instruction_addr  <= NB_PC'(wordIdx) << 2;
                            o_instruction_write <= 1'b1;
                            state               <= LOAD_WRITE;
                        end
                    end
                end
                LOAD_WRITE: begin
                    wordIdx <= wordIdx + NB_BYTE'(1);
                    if (wordIdx + NB_BYTE'(1) == wordCnt) begin
                        endAddr   <= NB_PC'(wordCnt) << 2;
                        ackCnt    <= 1'b0;
                        o_cpu_rst <= 1'b1;
                        state     <= LOAD_ACK;
                    end else begin
                        state <= LOAD_BYTE;
                    end
                end
                LOAD_ACK: begin
                    if (!ackCnt) begin
                        ackCnt    <= 1'b1;
                        o_cpu_rst <= 1'b1;
                    end else begin
                        state <= ACK_SEND;
                    end
                end
                ACK_SEND: if (!serBusy) state <= IDLE;
                RUN: begin
                    if (runGo) cycleCnt <= cycleCnt + CYC_W'(1);
                    else       state    <= DUMP_SET;
                end
                STEP: state <= DUMP_SET;
                DUMP_SET: begin
                    if (dumpIdx != '0 && dumpIdx <= DIDX_W'(N_REG))
                        o_reg_index_addr <= IDX_W'(dumpIdx - DIDX_W'(1));
                    else if (dumpIdx > DIDX_W'(N_REG))
                        o_memory_addr <= NB_DATA'(dumpIdx - DIDX_W'(N_REG + 1)) << 2;
                    state <= DUMP_WAIT;
                end
                DUMP_WAIT: state <= DUMP_CAP;
                DUMP_CAP:  state <= DUMP_SEND;
                DUMP_SEND: begin
                    if (!serBusy) begin
                        if (dumpIdx == DIDX_W'(DUMP_WORDS - 1)) begin
                            state <= IDLE;
                        end else begin
                            dumpIdx <= dumpIdx + DIDX_W'(1);
                            state   <= DUMP_SET;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    debug_word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clk      (i_clk),
        .rstN     (i_rst_n),
        .load     (serLoad),
        .single   (serSingle),
        .word     (serWord),
        .txTdata  (o_tx_data),
        .txTvalid (o_tx_valid),
        .txTready (i_tx_ready),
        .busy     (serBusy)
    );

endmodule
